// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential repeated-subtraction divider.
package seq_div_pkg;

  localparam int DIV_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_datapath.sv
// Divider datapath: remainder/divisor/quotient registers, comparator,
// subtractor and quotient incrementer, steered by the controlpath.
module div_datapath #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         sub_en,
  input  logic         ld_zero,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         r_ge_d,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  logic [W-1:0] r;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic         dz;

  assign r_ge_d = (r >= d);

  // The results are architecturally visible from reset, so data registers clear too.
  always_ff @(posedge clk) begin
    if (rst) begin
      r  <= '0;
      d  <= '0;
      q  <= '0;
      dz <= 1'b0;
    end else if (ld_zero) begin
      r  <= a;
      d  <= b;
      q  <= '1;
      dz <= 1'b1;
    end else if (ld) begin
      r  <= a;
      d  <= b;
      q  <= '0;
      dz <= 1'b0;
    end else if (sub_en) begin
      r  <= r - d;
      q  <= q + W'(1);
    end
  end

  assign quotient    = q;
  assign remainder   = r;
  assign div_by_zero = dz;

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned divider: start/done handshake controlpath driving a
// repeated-subtraction datapath, one subtraction per clock.
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         done,
  output logic         busy,
  output logic         div_by_zero
);

  div_state_t state;
  div_state_t state_nx;
  logic       accept;
  logic       b_zero;
  logic       ld;
  logic       ld_zero;
  logic       sub_en;
  logic       r_ge_d;

  assign accept  = (state == IDLE) && start;
  assign b_zero  = (b == '0);
  assign ld      = accept && !b_zero;
  assign ld_zero = accept && b_zero;
  assign sub_en  = (state == SUB) && r_ge_d;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = b_zero ? DONE : SUB;
      SUB:     if (!r_ge_d) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  assign done = (state == DONE);
  assign busy = (state != IDLE);

  div_datapath #(.W(W)) u_dp (
    .clk         (clk),
    .rst         (rst),
    .ld          (ld),
    .sub_en      (sub_en),
    .ld_zero     (ld_zero),
    .a           (a),
    .b           (b),
    .r_ge_d      (r_ge_d),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential unsigned integer divider built by repeated subtraction: the inverse companion of the team's shift-free repeated-addition multiplier, sharing the same start/done handshake style. Operands load on a `start` pulse, and one subtraction runs per clock. `done` pulses when the quotient and remainder are valid. It sits beside the multiplier in the sequential arithmetic environment and is driven by the same kind of directed bench.

## Interface
- `W`, default 8: operand, quotient and remainder width.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  W  dividend; captured on the accepting edge.
- `b`  in  W  divisor; captured on the accepting edge.
- `quotient`  out  W  result; valid from `done` until the next accepted `start`.
- `remainder`  out  W  result; same validity as `quotient`.
- `done`  out  1  one-cycle completion pulse.
- `busy`  out  1  high in SUB and DONE.
- `div_by_zero`  out  1  set with `done` when `b` was 0; held with the results.

## Operation
- States: IDLE, SUB, DONE.
- IDLE, `start`=1, captured `b`≠0:
  - R←`a`, D←`b`, Q←0
  - go to SUB
- IDLE, `start`=1, `b`=0:
  - Q←all-ones, R←`a`, `div_by_zero`←1
  - go directly to DONE
- SUB, each cycle:
  - if R≥D: R←R−D, Q←Q+1, stay in SUB.
  - otherwise go to DONE.
  - The compare is an unsigned W-bit compare.
  - The subtraction never underflows.
  - Q cannot exceed 2^W−1, so no overflow occurs.
- DONE: `done`=1 for exactly this cycle, then go to IDLE unconditionally.
- `quotient`/`remainder` are driven from Q/R. They must not be read before `done`.
- `div_by_zero` clears on the next accepted `start`.
- `start` in SUB or DONE is ignored; it is not queued. A new request is accepted only while in IDLE.
- `a`/`b` may change freely after the accepting edge. Only the captured copies are used.

## Timing
- Reset values:
  - state IDLE
  - `quotient`=0, `remainder`=0
  - `done`=0, `busy`=0, `div_by_zero`=0
- Latency, counting the accepting edge as edge 0:
  - `done` is high in the cycle after edge q+1, where q is the final quotient.
  - Divide by zero: `done` is high in the cycle after edge 0.
- Worst case: `a`=2^W−1, `b`=1 gives 2^W cycles to `done`.
- `busy` rises after edge 0 and falls together with `done`.
- Back-to-back operation: holding `start` high, the next request is accepted on the edge that leaves DONE+1. The minimum gap between accepting edges is q+3.
- Reset mid-operation (`rst` in any state):
  - on the next edge, return to IDLE with reset values.
  - `rst` wins over a simultaneous `start`.
  - no `done` pulse is produced for the aborted operation.

## Structure
- Package `seq_div_pkg`:
  - state enum `div_state_t` {IDLE, SUB, DONE}
  - default width constant `DIV_W`=8
- Sub-module `div_datapath` holds:
  - registers R, D, Q
  - the comparator `r_ge_d`
  - subtractor and incrementer
- `div_datapath` control inputs: `ld`, `sub_en`, `ld_zero`.
- The top level holds the FSM (controlpath) and instantiates `div_datapath`. This mirrors the multiplier's datapath/controlpath split.

## Test plan
- `a`=8, `b`=5, `start` pulse → `quotient`=1, `remainder`=3; `done` in the cycle after edge 2; `div_by_zero`=0.
- `a`=42, `b`=6 → `quotient`=7, `remainder`=0; `done` after edge 8; results held stable until the next `start`.
- `a`=3, `b`=7 → `quotient`=0, `remainder`=3; `done` after edge 1.
- `a`=200, `b`=0 → `div_by_zero`=1, `quotient`=255, `remainder`=200; `done` after edge 0. A following `a`=10, `b`=5 request clears `div_by_zero` and gives `quotient`=2, `remainder`=0.
- `a`=255, `b`=1 with `start` re-pulsed mid-run → second `start` ignored; `quotient`=255, `remainder`=0; `done` after edge 256.
- `a`=100, `b`=3, `rst` asserted 10 cycles after accept → all outputs 0 next cycle, no `done`. A subsequent `a`=7, `b`=6 request gives `quotient`=1, `remainder`=1.
